// File: rtl/window_buf_pkg.sv
// Shared types and helpers for the window line buffer.
package window_buf_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    READY  = 2'd1,
    REFILL = 2'd2
  } state_t;

  localparam int unsigned PAD_ZERO = 0;
  localparam int unsigned PAD_WRAP = 1;

  function automatic int unsigned words_per_line(input int unsigned cols,
                                                 input int unsigned word_elems);
    return cols / word_elems;
  endfunction

endpackage

// File: rtl/window_mux.sv
// Selects WIN_W elements of one line ending at col, with left-edge padding.
module window_mux
  import window_buf_pkg::*;
#(
  parameter int unsigned ELEM_W   = 8,
  parameter int unsigned COLS     = 16,
  parameter int unsigned WIN_W    = 4,
  parameter int unsigned PAD_MODE = PAD_ZERO
) (
  input  logic [COLS-1:0][ELEM_W-1:0]  line,
  input  logic [$clog2(COLS)-1:0]      col,
  output logic [WIN_W-1:0][ELEM_W-1:0] win_c
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned KW = (WIN_W > 1) ? $clog2(WIN_W) : 1;

  int idx;

  // win_c[k] holds column col-k, so the leftmost column lands in the MSBs
  always_comb begin
    win_c = '0;
    idx   = 0;
    for (int k = 0; k < WIN_W; k++) begin
      idx = int'(col) - k;
      if (int'(col) < int'(COLS)) begin
        if (idx >= 0) begin
          win_c[KW'(k)] = line[CW'(idx)];
        end else if (PAD_MODE == PAD_WRAP) begin
          win_c[KW'(k)] = line[CW'(idx + int'(COLS))];
        end
      end
    end
  end

endmodule

// File: rtl/window_line_buffer.sv
// ROWS x COLS line buffer with word-wise fill, line scroll/refill and
// registered ROWS x WIN_W window reads.
module window_line_buffer
  import window_buf_pkg::*;
#(
  parameter int unsigned ELEM_W     = 8,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 16,
  parameter int unsigned WORD_ELEMS = 4,
  parameter int unsigned WIN_W      = 4,
  parameter int unsigned PAD_MODE   = PAD_ZERO
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ELEM_W*WORD_ELEMS-1:0]   in_data,
  input  logic                           shift_req,
  input  logic                           win_req,
  input  logic [$clog2(COLS)-1:0]        win_col,
  output logic                           win_valid,
  output logic [ELEM_W*ROWS*WIN_W-1:0]   win_data,
  output logic                           full,
  output logic                           busy
);

  localparam int unsigned WPL = words_per_line(COLS, WORD_ELEMS);
  localparam int unsigned WW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned EW  = (WORD_ELEMS > 1) ? $clog2(WORD_ELEMS) : 1;
  localparam int unsigned CW  = $clog2(COLS);
  localparam logic [WW-1:0] LAST_WORD = WW'(WPL - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  logic [COLS-1:0][ELEM_W-1:0]  mem [ROWS];
  logic [WIN_W-1:0][ELEM_W-1:0] win_row [ROWS];
  logic [ROWS-1:0][WIN_W-1:0][ELEM_W-1:0] win_flat;
  logic [WORD_ELEMS-1:0][ELEM_W-1:0]      in_word;

  state_t        state, state_d;
  logic [RW-1:0] wr_row, wr_row_d, row_sel;
  logic [WW-1:0] wr_word, wr_word_d;
  logic [CW-1:0] wr_base;
  logic          do_write, do_shift, do_win;

  assign in_word = in_data;
  assign row_sel = (state == REFILL) ? LAST_ROW : wr_row;
  assign wr_base = CW'(int'(wr_word) * int'(WORD_ELEMS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      wr_row  <= '0;
      wr_word <= '0;
    end else begin
      state   <= state_d;
      wr_row  <= wr_row_d;
      wr_word <= wr_word_d;
    end
  end

  // Fill/ready/refill sequencing; clear overrides everything but rst
  always_comb begin
    state_d   = state;
    wr_row_d  = wr_row;
    wr_word_d = wr_word;
    do_write  = 1'b0;
    do_shift  = 1'b0;
    do_win    = 1'b0;
    unique case (state)
      FILL: begin
        if (in_valid) begin
          do_write = 1'b1;
          if (wr_word == LAST_WORD) begin
            wr_word_d = '0;
            if (wr_row == LAST_ROW) state_d = READY;
            else                    wr_row_d = wr_row + RW'(1);
          end else begin
            wr_word_d = wr_word + WW'(1);
          end
        end
      end
      READY: begin
        do_win = win_req;
        if (shift_req) begin
          do_shift  = 1'b1;
          wr_word_d = '0;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        if (in_valid) begin
          do_write = 1'b1;
          if (wr_word == LAST_WORD) begin
            wr_word_d = '0;
            state_d   = READY;
          end else begin
            wr_word_d = wr_word + WW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
    if (clear) begin
      state_d   = FILL;
      wr_row_d  = '0;
      wr_word_d = '0;
      do_write  = 1'b0;
      do_shift  = 1'b0;
      do_win    = 1'b0;
    end
  end

  // Status flags follow the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b1;
      full     <= 1'b0;
      busy     <= 1'b1;
    end else begin
      in_ready <= (state_d != READY);
      full     <= (state_d == READY);
      busy     <= (state_d != READY);
    end
  end

  // Line storage: scroll up on shift, else word write; first element in MSBs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) mem[RW'(r)] <= '0;
    end else if (do_shift) begin
      for (int r = 0; r < ROWS - 1; r++) mem[RW'(r)] <= mem[RW'(r + 1)];
    end else if (do_write) begin
      for (int e = 0; e < WORD_ELEMS; e++)
        mem[row_sel][wr_base + CW'(e)] <= in_word[EW'(WORD_ELEMS - 1 - e)];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_mux
    window_mux #(
      .ELEM_W   (ELEM_W),
      .COLS     (COLS),
      .WIN_W    (WIN_W),
      .PAD_MODE (PAD_MODE)
    ) u_mux (
      .line  (mem[r]),
      .col   (win_col),
      .win_c (win_row[r])
    );
    assign win_flat[ROWS-1-r] = win_row[r];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_data  <= '0;
    end else begin
      win_valid <= do_win;
      if (do_win) win_data <= win_flat;
    end
  end

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed bench for window_line_buffer: one zero-pad and one wrap-pad instance.
module tb_window_line_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         shift_req;
  logic         win_req;
  logic [3:0]   win_col;
  logic         in_ready, win_valid, full, busy;
  logic [127:0] win_data;
  logic         in_ready_w, win_valid_w, full_w, busy_w;
  logic [127:0] win_data_w;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  window_line_buffer dut_zero (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .shift_req(shift_req), .win_req(win_req), .win_col(win_col),
    .win_valid(win_valid), .win_data(win_data), .full(full), .busy(busy)
  );

  window_line_buffer #(.PAD_MODE(1)) dut_wrap (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_data), .shift_req(shift_req), .win_req(win_req), .win_col(win_col),
    .win_valid(win_valid_w), .win_data(win_data_w), .full(full_w), .busy(busy_w)
  );

  function automatic logic [31:0] mk_word(input logic [7:0] b);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams n consecutive words whose bytes count up from base
  task automatic stream(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = mk_word(base + 8'(4 * i));
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic read_win(input logic [3:0] col);
    win_req = 1'b1;
    win_col = col;
    step();
    win_req = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({in_ready, full, busy, win_valid} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 1010", {in_ready, full, busy, win_valid});
    end
    tests_run++;
    if (win_data !== 128'd0) begin
      tests_failed++;
      $display("FAIL reset_win_data: got %h want 0", win_data);
    end
  endtask

  task automatic test_fill();
    stream(8'h00, 15);
    tests_run++;
    if ({in_ready, full} !== 2'b10) begin
      tests_failed++;
      $display("FAIL fill_15: ready/full got %b want 10", {in_ready, full});
    end
    stream(8'h3C, 1);
    tests_run++;
    if ({in_ready, full, busy} !== 3'b010) begin
      tests_failed++;
      $display("FAIL fill_done: ready/full/busy got %b want 010", {in_ready, full, busy});
    end
  endtask

  task automatic test_window();
    read_win(4'd7);
    tests_run++;
    if (win_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL win_valid_pulse: got %b want 1", win_valid);
    end
    tests_run++;
    if (win_data[127:96] !== 32'h04050607 || win_data[31:0] !== 32'h34353637) begin
      tests_failed++;
      $display("FAIL win_col7: line0 %h line3 %h want 04050607 34353637",
               win_data[127:96], win_data[31:0]);
    end
    step();
    tests_run++;
    if (win_valid !== 1'b0 || win_data[127:96] !== 32'h04050607) begin
      tests_failed++;
      $display("FAIL win_hold: valid %b line0 %h want 0 04050607", win_valid, win_data[127:96]);
    end
  endtask

  task automatic test_left_edge();
    read_win(4'd1);
    tests_run++;
    if (win_data[127:96] !== 32'h00000001) begin
      tests_failed++;
      $display("FAIL pad_zero_col1: got %h want 00000001", win_data[127:96]);
    end
    tests_run++;
    if (win_data_w[127:96] !== 32'h0E0F0001 || win_data_w[63:32] !== 32'h2E2F2021) begin
      tests_failed++;
      $display("FAIL pad_wrap_col1: line0 %h line2 %h want 0E0F0001 2E2F2021",
               win_data_w[127:96], win_data_w[63:32]);
    end
    read_win(4'd0);
    tests_run++;
    if (win_data[95:64] !== 32'h00000010 || win_data_w[95:64] !== 32'h1D1E1F10) begin
      tests_failed++;
      $display("FAIL pad_col0_line1: zero %h wrap %h want 00000010 1D1E1F10",
               win_data[95:64], win_data_w[95:64]);
    end
  endtask

  task automatic test_shift_refill();
    shift_req = 1'b1;
    step();
    shift_req = 1'b0;
    tests_run++;
    if ({in_ready, full, busy} !== 3'b101) begin
      tests_failed++;
      $display("FAIL refill_flags: ready/full/busy got %b want 101", {in_ready, full, busy});
    end
    read_win(4'd7);
    tests_run++;
    if (win_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL win_in_refill: win_valid got %b want 0", win_valid);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      step();
      tests_run++;
      if (full !== 1'b0) begin
        tests_failed++;
        $display("FAIL refill_gap_%0d: full got %b want 0", i, full);
      end
      stream(8'hA0 + 8'(4 * i), 1);
    end
    tests_run++;
    if ({in_ready, full} !== 2'b01) begin
      tests_failed++;
      $display("FAIL refill_done: ready/full got %b want 01", {in_ready, full});
    end
    read_win(4'd15);
    tests_run++;
    if (win_data[127:96] !== 32'h1C1D1E1F || win_data[31:0] !== 32'hACADAEAF) begin
      tests_failed++;
      $display("FAIL after_shift_col15: line0 %h line3 %h want 1C1D1E1F ACADAEAF",
               win_data[127:96], win_data[31:0]);
    end
    read_win(4'd3);
    tests_run++;
    if (win_data[63:32] !== 32'h30313233 || win_data[31:0] !== 32'hA0A1A2A3) begin
      tests_failed++;
      $display("FAIL after_shift_col3: line2 %h line3 %h want 30313233 A0A1A2A3",
               win_data[63:32], win_data[31:0]);
    end
  endtask

  task automatic test_win_and_shift();
    win_req   = 1'b1;
    shift_req = 1'b1;
    win_col   = 4'd3;
    step();
    win_req   = 1'b0;
    shift_req = 1'b0;
    tests_run++;
    if (win_valid !== 1'b1 || win_data[127:96] !== 32'h10111213 || win_data[31:0] !== 32'hA0A1A2A3) begin
      tests_failed++;
      $display("FAIL simul_pre_shift: valid %b line0 %h line3 %h want 1 10111213 A0A1A2A3",
               win_valid, win_data[127:96], win_data[31:0]);
    end
    tests_run++;
    if ({in_ready, full} !== 2'b10) begin
      tests_failed++;
      $display("FAIL simul_refill: ready/full got %b want 10", {in_ready, full});
    end
    stream(8'hB0, 4);
    read_win(4'd3);
    tests_run++;
    if (win_data[127:96] !== 32'h20212223 || win_data[31:0] !== 32'hB0B1B2B3) begin
      tests_failed++;
      $display("FAIL simul_after: line0 %h line3 %h want 20212223 B0B1B2B3",
               win_data[127:96], win_data[31:0]);
    end
  endtask

  task automatic test_clear();
    win_req = 1'b1;
    clear   = 1'b1;
    win_col = 4'd5;
    step();
    win_req = 1'b0;
    clear   = 1'b0;
    tests_run++;
    if ({in_ready, full, busy, win_valid} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL clear_ready: flags got %b want 1010", {in_ready, full, busy, win_valid});
    end
    stream(8'hC0, 5);
    clear = 1'b1;
    step();
    clear = 1'b0;
    tests_run++;
    if ({in_ready, full, win_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL clear_midfill: ready/full/valid got %b want 100", {in_ready, full, win_valid});
    end
    read_win(4'd7);
    tests_run++;
    if (win_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL win_in_fill: win_valid got %b want 0", win_valid);
    end
    stream(8'h40, 16);
    read_win(4'd7);
    tests_run++;
    if (full !== 1'b1 || win_data[127:96] !== 32'h44454647 || win_data[31:0] !== 32'h74757677) begin
      tests_failed++;
      $display("FAIL clear_refill_win: full %b line0 %h line3 %h want 1 44454647 74757677",
               full, win_data[127:96], win_data[31:0]);
    end
  endtask

  task automatic test_reset_mid_fill();
    clear = 1'b1;
    step();
    clear = 1'b0;
    stream(8'hD0, 5);
    rst = 1'b1;
    #2;
    tests_run++;
    if ({in_ready, full, win_valid} !== 3'b100 || win_data !== 128'd0) begin
      tests_failed++;
      $display("FAIL rst_midfill: ready/full/valid %b data %h want 100 0",
               {in_ready, full, win_valid}, win_data);
    end
    rst = 1'b0;
    step();
    stream(8'h80, 16);
    read_win(4'd15);
    tests_run++;
    if (win_data[127:96] !== 32'h8C8D8E8F || win_data[31:0] !== 32'hBCBDBEBF) begin
      tests_failed++;
      $display("FAIL rst_refill_win: line0 %h line3 %h want 8C8D8E8F BCBDBEBF",
               win_data[127:96], win_data[31:0]);
    end
    read_win(4'd2);
    tests_run++;
    if (win_data_w[95:64] !== 32'h9F909192) begin
      tests_failed++;
      $display("FAIL rst_wrap_col2: line1 %h want 9F909192", win_data_w[95:64]);
    end
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    shift_req = 1'b0;
    win_req   = 1'b0;
    win_col   = '0;
    step();
    step();
    rst = 1'b0;
    step();
    test_reset();
    test_fill();
    test_window();
    test_left_edge();
    test_shift_refill();
    test_win_and_shift();
    test_clear();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/window_line_buffer.md
Name: window_line_buffer

Overview:
- Parametrised 2-D line buffer for the filter datapath. Streams packed element words in through a valid/ready handshake, auto-fills ROWS lines of COLS elements, and serves registered ROWS x WIN_W windows ending at a requested column.
- Supports line scroll with automatic refill of the bottom line, and zero or wrap padding at the left edge.
- Sits between the input word fetcher and the MAC/compare array.

Parameters:
- ELEM_W, 8, bits per element
- ROWS, 4, lines held (window height)
- COLS, 16, elements per line; must be a multiple of WORD_ELEMS
- WORD_ELEMS, 4, elements per input word
- WIN_W, 4, window width in elements; must be <= COLS
- PAD_MODE, 0, left-edge handling: 0 = zero padding, 1 = wrap to end of line

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush to empty
- in_valid  in  1  input word valid
- in_ready  out  1  buffer accepts a word this cycle
- in_data  in  ELEM_W*WORD_ELEMS  packed word; first element in MSBs
- shift_req  in  1  drop top line and refill the bottom line
- win_req  in  1  window read request
- win_col  in  $clog2(COLS)  rightmost column of the window
- win_valid  out  1  win_data valid (one-cycle pulse)
- win_data  out  ELEM_W*ROWS*WIN_W  window; line 0 in MSBs; within a line, column win_col-WIN_W+1 first
- full  out  1  all lines loaded; windows may be read
- busy  out  1  fill or refill in progress

Behaviour:
- Reset: all elements 0; state FILL; wr_row = 0; wr_word = 0; in_ready = 1; win_valid = 0; win_data = 0; full = 0; busy = 1.
- States:
  - FILL: in_ready = 1. Each accepted word writes line wr_row, elements wr_word*WORD_ELEMS .. +WORD_ELEMS-1. wr_word increments and wraps at COLS/WORD_ELEMS-1, then wr_row increments. When the last word of line ROWS-1 is accepted, go to READY.
  - READY: full = 1, busy = 0, in_ready = 0. shift_req copies line i+1 into line i for i < ROWS-1, sets wr_word = 0, and goes to REFILL. Line ROWS-1 keeps stale data until it is overwritten.
  - REFILL: in_ready = 1, full = 0. Accepted words write line ROWS-1. After the last word, go to READY.
- Handshake: a transfer occurs when in_valid && in_ready. Data is held by the source until it is accepted.
- Window read:
  - Accepted only in READY. win_data and win_valid are registered, so latency is 1 cycle.
  - win_req outside READY is ignored and win_valid stays 0.
  - win_data holds its last value between requests.
- Left edge: column c = win_col - k for k > win_col.
  - PAD_MODE 0: the element reads as 0.
  - PAD_MODE 1: the element reads column COLS + c.
- win_col >= COLS (non-power-of-2 COLS): the whole window reads as 0 and win_valid still pulses.
- Simultaneous win_req and shift_req in READY: the window is captured from pre-shift contents, and the shift takes effect the same edge.
- clear: highest priority after rst. Returns to the FILL state, pointers, and flags of reset but does not zero storage. A pending window is dropped (win_valid = 0 next cycle).
- shift_req outside READY is ignored.
- rst mid-fill or mid-refill: immediate return to the reset state.

Decomposition:
- Package window_buf_pkg: state enum (FILL, READY, REFILL); PAD_ZERO/PAD_WRAP constants; helper function for words-per-line.
- One sub-module, window_mux: combinational column select with padding for one line, instantiated ROWS times. The top level holds storage, the FSM, and the output register.

Test Plan:
- Fill: default params, stream 16 words 0x00010203, 0x04050607, ... with in_valid always high. Required: in_ready deasserts after the 16th accept; full = 1 the next cycle.
- Window read: win_req with win_col = 7. Required: win_valid 1 cycle later; line 0 bytes = 04 05 06 07; line 3 bytes = 34 35 36 37.
- Left edge, PAD_MODE 0: win_col = 1. Required: line 0 = 00 00 00 01. Repeat with PAD_MODE 1: line 0 = 0E 0F 00 01.
- Shift and refill: shift_req, then 4 words 0xA0A1A2A3 ... with in_valid gaps.
  - Required: full = 0 during refill; win_req ignored; afterwards line 0 = old line 1 and line 3 = A0..AF.
- Simultaneous win_req and shift_req in READY. Required: the window matches pre-shift data and the state is REFILL.
- Reset or clear mid-fill after 5 words:
  - Required: in_ready = 1, full = 0, win_valid = 0.
  - A full refill then produces the correct windows with no stale pointer offset.
